// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the two-requester BRAM port arbiter.
package bram_arb_pkg;

    localparam int ARB_M0            = 0;
    localparam int ARB_M1            = 1;
    localparam int RUN_W             = 4;
    localparam int DEFAULT_MAX_BURST = 4;

    typedef logic [RUN_W-1:0] run_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

endpackage

// File: rtl/bram_arb_grant.sv
// Round-robin grant decision with a bounded burst: the owner keeps the port
// while the other side waits only until its run reaches max_burst.
module bram_arb_grant
    import bram_arb_pkg::*;
#(
    parameter int max_burst = DEFAULT_MAX_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    owner_e r_owner;
    run_t   r_run;
    logic   w_owner_may_continue;
    owner_e w_grantee;
    logic   w_any_gnt;

    assign w_owner_may_continue = (r_run < run_t'(max_burst));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                if (r_owner == OWN_M0) begin
                    gnt0 = w_owner_may_continue;
                    gnt1 = !w_owner_may_continue;
                end else begin
                    gnt1 = w_owner_may_continue;
                    gnt0 = !w_owner_may_continue;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign w_any_gnt = gnt0 || gnt1;
    assign w_grantee = gnt1 ? OWN_M1 : OWN_M0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_M0;
            r_run   <= '0;
        end else if (w_any_gnt) begin
            if (w_grantee == r_owner) begin
                // Saturate so a lone requester never wraps and loses priority.
                if (r_run < run_t'(max_burst)) begin
                    r_run <= r_run + run_t'(1);
                end
            end else begin
                r_owner <= w_grantee;
                r_run   <= run_t'(1);
            end
        end else begin
            r_run <= '0;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-master front end for one BRAM port: grant, request mux, and the
// one-cycle read-valid tracking for each master.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int addr_width = 12,
    parameter int max_burst  = DEFAULT_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [addr_width-1:0] m0_addr,
    input  logic [3:0]            m0_we,
    input  logic [31:0]           m0_wdata,
    input  logic                  m1_req,
    input  logic [addr_width-1:0] m1_addr,
    input  logic [3:0]            m1_we,
    input  logic [31:0]           m1_wdata,
    output logic                  m0_ack,
    output logic                  m1_ack,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [31:0]           m0_rdata,
    output logic [31:0]           m1_rdata,
    output logic [addr_width-1:0] bram_addr,
    output logic [3:0]            bram_we,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout
);

    logic [1:0] w_gnt;
    logic [1:0] w_rvalid;
    logic [3:0] w_req_we [2];
    logic [3:0] w_bram_we;

    assign w_req_we[ARB_M0] = m0_we;
    assign w_req_we[ARB_M1] = m1_we;

    bram_arb_grant #(
        .max_burst(max_burst)
    ) u_grant (
        .clk (clk),
        .rst (rst),
        .req0(m0_req),
        .req1(m1_req),
        .gnt0(w_gnt[ARB_M0]),
        .gnt1(w_gnt[ARB_M1])
    );

    // Address and data default to m0 when idle; only the enables matter then.
    assign bram_addr = w_gnt[ARB_M1] ? m1_addr  : m0_addr;
    assign bram_din  = w_gnt[ARB_M1] ? m1_wdata : m0_wdata;

    always_comb begin
        w_bram_we = 4'b0000;
        if (w_gnt[ARB_M0]) begin
            w_bram_we = m0_we;
        end else if (w_gnt[ARB_M1]) begin
            w_bram_we = m1_we;
        end
    end
    assign bram_we = w_bram_we;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic r_rd;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd <= 1'b0;
                end else begin
                    r_rd <= w_gnt[gi] && (w_req_we[gi] == 4'b0000);
                end
            end
            // Masked while in reset so a read caught by reset never reports.
            assign w_rvalid[gi] = r_rd && !rst;
        end
    endgenerate

    assign m0_ack    = w_gnt[ARB_M0];
    assign m1_ack    = w_gnt[ARB_M1];
    assign m0_rvalid = w_rvalid[ARB_M0];
    assign m1_rvalid = w_rvalid[ARB_M1];
    assign m0_rdata  = bram_dout;
    assign m1_rdata  = bram_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural BRAM and a read-data scoreboard.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m1_req;
    logic [11:0] m0_addr, m1_addr;
    logic [3:0]  m0_we, m1_we;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [11:0] bram_addr;
    logic [3:0]  bram_we;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    bram_arbiter #(.addr_width(12), .max_burst(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    // Byte-enabled BRAM, one-cycle registered read
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bram_we[i]) mem[bram_addr][8*i +: 8] <= bram_din[8*i +: 8];
        end
        bram_dout <= mem[bram_addr];
    end

    logic [31:0] ref_mem [0:4095];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          pend0 = 1'b0;
    bit          pend1 = 1'b0;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_mis++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic sb_pop(input string tag, input bit side, input logic [31:0] got);
        logic [31:0] want;
        if ((side ? q1.size() : q0.size()) == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL %s: got %h expected <scoreboard empty>", tag, got);
        end else begin
            want = side ? q1.pop_front() : q0.pop_front();
            chk(tag, got, want);
        end
    endtask

    task automatic apply(input logic [11:0] a, input logic [3:0] w, input logic [31:0] d, input bit side);
        if (w == 4'b0000) begin
            if (side) q1.push_back(ref_mem[a]);
            else      q0.push_back(ref_mem[a]);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    // One clock of stimulus: drive, then check rvalid/rdata from the previous
    // grant and the acks/BRAM port for this cycle.
    task automatic cyc(input logic r,
                       input logic r0, input logic [11:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                       input logic r1, input logic [11:0] a1, input logic [3:0] w1, input logic [31:0] d1,
                       input logic e0, input logic e1);
        logic [3:0] exp_we;
        @(posedge clk);
        #1;
        rst = r;
        m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
        m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
        #3;
        chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, pend0 & ~r});
        chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, pend1 & ~r});
        if (pend0 && !r) sb_pop("m0_rdata", 1'b0, m0_rdata);
        if (pend1 && !r) sb_pop("m1_rdata", 1'b1, m1_rdata);
        if (r) begin
            q0.delete();
            q1.delete();
        end
        chk("m0_ack", {31'b0, m0_ack}, {31'b0, e0});
        chk("m1_ack", {31'b0, m1_ack}, {31'b0, e1});
        exp_we = e0 ? w0 : (e1 ? w1 : 4'b0000);
        chk("bram_we", {28'b0, bram_we}, {28'b0, exp_we});
        if (e0) begin
            chk("bram_addr", {20'b0, bram_addr}, {20'b0, a0});
            if (w0 != 4'b0000) chk("bram_din", bram_din, d0);
            apply(a0, w0, d0, 1'b0);
        end else if (e1) begin
            chk("bram_addr", {20'b0, bram_addr}, {20'b0, a1});
            if (w1 != 4'b0000) chk("bram_din", bram_din, d1);
            apply(a1, w1, d1, 1'b1);
        end
        pend0 = e0 && (w0 == 4'b0000);
        pend1 = e1 && (w1 == 4'b0000);
        $display("t=%0t rst=%b req=%b%b ack=%b%b rvalid=%b%b bram_we=%b rdata=%h",
                 $time, r, r1, r0, m1_ack, m0_ack, m1_rvalid, m0_rvalid, bram_we, bram_dout);
    endtask

    task automatic idle(input logic r);
        cyc(r, 0, 12'h000, 4'h0, 32'h0, 0, 12'h000, 4'h0, 32'h0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_addr = '0; m0_we = '0; m0_wdata = '0;
        m1_req = 0; m1_addr = '0; m1_we = '0; m1_wdata = '0;

        // Reset: requests are ignored, no enables
        idle(1);
        cyc(1, 1, 12'h010, 4'hF, 32'h12345678, 1, 12'h020, 4'hF, 32'h9ABCDEF0, 0, 0);
        idle(0);

        // Preload through m0, then single read
        cyc(0, 1, 12'h010, 4'hF, 32'hDEADBEEF, 0, 12'h000, 4'h0, 32'h0, 1, 0);
        cyc(0, 1, 12'h020, 4'hF, 32'h11223344, 0, 12'h000, 4'h0, 32'h0, 1, 0);
        idle(0);
        cyc(0, 1, 12'h010, 4'h0, 32'h0, 0, 12'h000, 4'h0, 32'h0, 1, 0);
        idle(0);

        // Byte write by m1 then read back
        cyc(0, 0, 12'h000, 4'h0, 32'h0, 1, 12'h020, 4'b0100, 32'h00AB0000, 0, 1);
        cyc(0, 0, 12'h000, 4'h0, 32'h0, 1, 12'h020, 4'h0, 32'h0, 0, 1);
        idle(0);

        // Read after write across masters
        cyc(0, 1, 12'h030, 4'hF, 32'hCAFEF00D, 0, 12'h000, 4'h0, 32'h0, 1, 0);
        cyc(0, 0, 12'h000, 4'h0, 32'h0, 1, 12'h030, 4'h0, 32'h0, 0, 1);
        idle(0);

        // Burst limit from reset with both requesting continuously
        idle(1);
        for (int k = 0; k < 10; k++) begin
            logic exp1;
            exp1 = (k >= 4) && (k < 8);
            cyc(0, 1, 12'h010, 4'h0, 32'h0, 1, 12'h020, 4'h0, 32'h0, !exp1, exp1);
        end
        idle(0);

        // Lone m1 is never forced to yield; then m0 joins and wins at once
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 12'h000, 4'h0, 32'h0, 1, 12'h030, 4'h0, 32'h0, 0, 1);
        end
        cyc(0, 1, 12'h010, 4'h0, 32'h0, 1, 12'h030, 4'h0, 32'h0, 1, 0);
        idle(0);

        // Reset arriving the cycle after a granted read suppresses its rvalid
        cyc(0, 0, 12'h000, 4'h0, 32'h0, 1, 12'h020, 4'h0, 32'h0, 0, 1);
        cyc(0, 1, 12'h010, 4'h0, 32'h0, 0, 12'h000, 4'h0, 32'h0, 1, 0);
        idle(1);
        cyc(0, 1, 12'h010, 4'h0, 32'h0, 1, 12'h020, 4'h0, 32'h0, 1, 0);
        idle(0);
        idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
